stage_dispatch: RTL and testbench
=================================

Name: stage_dispatch

Overview:
- Generalised inter-stage handoff between a producer stage (DMVM, softmax) and one or more identical consumer units (softmax, aggregator).
- Buffers producer results in a parametrised circular FIFO.
- Dispatches each entry to a free consumer lane with round-robin arbitration, and issues a one-cycle valid pulse with registered, held data.
- Replaces the single-consumer first-pop/pre-ready/valid-pulse logic with one block that supports multiple lanes, flush and overflow reporting.

Parameters:
- DATA_W, 64, width of one entry (packed coefficient/alpha vector plus node count).
- DEPTH, 16, FIFO entries; power of two, at least 2.
- NUM_LANES, 2, number of downstream consumer units; at least 1.
- AFULL_TH, DEPTH-2, occupancy at or above which almost_full_o asserts.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- wr_valid_i  in  1  producer push strobe (the producer's ready pulse).
- wr_data_i  in  DATA_W  entry to push.
- flush_i  in  1  synchronous FIFO clear.
- lane_pre_ready_i  in  NUM_LANES  per-lane pulse: the lane can accept its next job.
- lane_valid_o  out  NUM_LANES  one-cycle pulse per dispatched job.
- lane_data_o  out  NUM_LANES*DATA_W  per-lane job data; lane k occupies bits [(k+1)*DATA_W-1 : k*DATA_W].
- count_o  out  $clog2(DEPTH)+1  FIFO occupancy.
- full_o  out  1  count_o == DEPTH.
- almost_full_o  out  1  count_o >= AFULL_TH.
- overflow_o  out  1  sticky flag: a push was dropped.

Behaviour:
- Reset values:
  - All outputs are 0: lane_valid_o, lane_data_o, count_o, full_o, almost_full_o, overflow_o.
  - Internally, the read/write pointers are 0, all lane credits are 1, and the round-robin pointer is 0.
- FIFO behaviour:
  - Circular buffer; pointers wrap from DEPTH-1 to 0.
  - There is no fall-through. An entry written in cycle t is first poppable in cycle t+1.
- Push rules:
  - A push is accepted if not full, or if full with a pop in the same cycle; in that case count is unchanged.
  - A push while full with no pop is dropped and sets overflow_o. Pointers and count are unchanged.
- Lane credit (per lane):
  - Credit is 1 at reset, which is the "first job" condition.
  - Credit clears when a job is dispatched to the lane.
  - Credit sets on lane_pre_ready_i[k].
  - A pre_ready on a lane whose credit is already 1 is ignored, including in the cycle that lane is dispatched; credit ends at 0.
- Dispatch (per cycle):
  - Condition: count > 0, at least one credited lane, and flush_i low.
  - Action: exactly one entry pops to the first credited lane found searching from rr_ptr upward, modulo NUM_LANES.
  - rr_ptr then becomes granted lane + 1, modulo NUM_LANES.
  - At most one dispatch per cycle.
- Output timing:
  - In the cycle after the pop, lane_valid_o[k] is 1 for exactly one cycle and lane_data_o slice k carries the popped entry.
  - The data slice holds its value until the next dispatch to lane k.
  - Other lanes' slices are untouched.
- Latency: push at cycle t with an empty FIFO and a credited lane gives lane valid at t+2.
- Count update: count_o updates every cycle as +push_accepted - pop; full_o and almost_full_o are registered from the next count.
- flush_i (takes priority over everything in that cycle):
  - Pointers, count and overflow_o clear.
  - No dispatch, and no push accepted that cycle.
  - Lane credits and rr_ptr are unchanged, since lanes may be mid-job.
  - Data already issued stays held; no lane_valid_o in the following cycle.
- Reset mid-operation: all state returns to reset values at the next edge, and in-flight valid pulses are cancelled.
- NUM_LANES=1: degenerates to a single-consumer handoff (first pop on credit, subsequent pops on pre_ready).

Decomposition:
- Shared package params_pkg holds:
  - STAGE_FIFO_DEPTH.
  - SOFTMAX_LANES and AGGR_LANES.
  - Entry typedefs coef_t and aggr_t, reused as DATA_W sources.
- The circular buffer (storage, pointers, count, full, overflow) is a natural sub-module: stage_fifo.
- Credits, the round-robin arbiter and the output registers stay in stage_dispatch.

Test Plan:
- Reset, then one push (DATA_W=64, NUM_LANES=2) of 0x0123_4567_89AB_CDEF at cycle 0 -> lane_valid_o=2'b01 at cycle 2, with lane 0 data = 0x0123_4567_89AB_CDEF; count_o returns to 0.
- Four back-to-back pushes A,B,C,D with no pre_ready -> A to lane 0, B to lane 1, count_o stays at 2. Then pre_ready lane 1 -> C to lane 1. Then pre_ready lane 0 -> D to lane 0.
- 17 pushes with DEPTH=16 and all credits pre-consumed -> full_o=1 after the 16th, and almost_full_o=1 at count 14. The 17th is dropped with overflow_o=1, and count_o stays 16 until a pre_ready pops one.
- Full FIFO with simultaneous push and pop (pre_ready arrives, dispatch fires) -> push accepted, count_o stays 16, overflow_o stays 0.
- flush_i with count_o=5, asserted in the same cycle a lane is credited -> no valid next cycle, count_o=0, overflow_o cleared. A push in the next cycle dispatches normally 2 cycles later.
- pre_ready on an already-credited lane, and pre_ready coincident with dispatch to the same lane -> no extra dispatch; that lane's credit is 0 afterwards (verified by the next entry going to the other lane).

Source files
------------

// File: rtl/params_pkg.sv
// Parameters and entry types shared by the inter-stage handoff blocks.
// DMVM feeds softmax lanes with coef_t entries; softmax feeds aggregator lanes with aggr_t entries.
package params_pkg;

    localparam int STAGE_FIFO_DEPTH = 16;
    localparam int SOFTMAX_LANES    = 2;
    localparam int AGGR_LANES       = 2;

    typedef struct packed {
        logic [55:0] coef;
        logic [7:0]  node_cnt;
    } coef_t;

    typedef struct packed {
        logic [47:0] alpha;
        logic [15:0] node_cnt;
    } aggr_t;

    // Wraps a lane index that has run at most one lap past the lane count.
    function automatic int lane_wrap(input int idx, input int lanes);
        return (idx >= lanes) ? idx - lanes : idx;
    endfunction

endpackage

// File: rtl/stage_dispatch_if.sv
// Producer/consumer bundle of the stage handoff: push side, per-lane job side and FIFO status.
interface stage_dispatch_if
    import params_pkg::*;
#(
    parameter int DATA_W    = $bits(coef_t),
    parameter int DEPTH     = STAGE_FIFO_DEPTH,
    parameter int NUM_LANES = SOFTMAX_LANES
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                        wr_valid_i;
    logic [DATA_W-1:0]           wr_data_i;
    logic                        flush_i;
    logic [NUM_LANES-1:0]        lane_pre_ready_i;
    logic [NUM_LANES-1:0]        lane_valid_o;
    logic [NUM_LANES*DATA_W-1:0] lane_data_o;
    logic [CNT_W-1:0]            count_o;
    logic                        full_o;
    logic                        almost_full_o;
    logic                        overflow_o;

    modport master (
        output wr_valid_i, wr_data_i, flush_i, lane_pre_ready_i,
        input  lane_valid_o, lane_data_o, count_o, full_o, almost_full_o, overflow_o
    );

    modport slave (
        input  wr_valid_i, wr_data_i, flush_i, lane_pre_ready_i,
        output lane_valid_o, lane_data_o, count_o, full_o, almost_full_o, overflow_o
    );

endinterface

// File: rtl/stage_fifo.sv
// Circular buffer between stages: no fall-through, drop-on-full with a sticky overflow flag,
// flush clears pointers/count/overflow.
module stage_fifo
    import params_pkg::*;
#(
    parameter int DATA_W   = $bits(coef_t),
    parameter int DEPTH    = STAGE_FIFO_DEPTH,
    parameter int AFULL_TH = DEPTH - 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [DATA_W-1:0]        i_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [DATA_W-1:0]        o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_almost_full,
    output logic                     o_overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_full;
    logic              r_almost_full;
    logic              r_overflow;

    logic              w_push_ok;
    logic              w_pop_ok;
    logic [CW-1:0]     w_count_next;

    // A full FIFO still takes a push when an entry leaves in the same cycle.
    assign w_push_ok = i_push && !i_flush && (!r_full || i_pop);
    assign w_pop_ok  = i_pop && !i_flush;

    always_comb begin
        w_count_next = r_count;
        if (i_flush)
            w_count_next = '0;
        else if (w_push_ok && !w_pop_ok)
            w_count_next = r_count + 1'b1;
        else if (!w_push_ok && w_pop_ok)
            w_count_next = r_count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_count       <= w_count_next;
            r_full        <= (w_count_next == CW'(DEPTH));
            r_almost_full <= (w_count_next >= CW'(AFULL_TH));
            if (i_flush) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_push_ok)
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop_ok)
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                if (i_push && r_full && !w_pop_ok)
                    r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok)
            r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data        = r_mem[r_rd_ptr];
    assign o_count       = r_count;
    assign o_full        = r_full;
    assign o_almost_full = r_almost_full;
    assign o_overflow    = r_overflow;

endmodule

// File: rtl/stage_dispatch.sv
// Hands buffered producer results to NUM_LANES identical consumers: per-lane credit,
// round-robin grant, one-cycle valid pulse with data held until the lane's next job.
module stage_dispatch
    import params_pkg::*;
#(
    parameter int DATA_W    = $bits(coef_t),
    parameter int DEPTH     = STAGE_FIFO_DEPTH,
    parameter int NUM_LANES = SOFTMAX_LANES,
    parameter int AFULL_TH  = DEPTH - 2
) (
    input  logic             clk,
    input  logic             rst_n,
    stage_dispatch_if.slave  bus
);
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    logic [DATA_W-1:0]      w_fifo_data;
    logic [$clog2(DEPTH):0] w_count;
    logic                   w_full;
    logic                   w_almost_full;
    logic                   w_overflow;
    logic                   w_found;
    logic [LW-1:0]          w_grant;
    logic [LW-1:0]          w_scan;
    logic                   w_pop;

    logic [NUM_LANES-1:0]   r_credit;
    logic [LW-1:0]          r_rr_ptr;
    logic [NUM_LANES-1:0]   r_valid;
    logic [DATA_W-1:0]      r_data [NUM_LANES];

    stage_fifo #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AFULL_TH (AFULL_TH)
    ) u_fifo (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_push        (bus.wr_valid_i),
        .i_data        (bus.wr_data_i),
        .i_pop         (w_pop),
        .i_flush       (bus.flush_i),
        .o_data        (w_fifo_data),
        .o_count       (w_count),
        .o_full        (w_full),
        .o_almost_full (w_almost_full),
        .o_overflow    (w_overflow)
    );

    // First credited lane at or after the round-robin pointer.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_scan  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_scan = LW'(lane_wrap(int'(r_rr_ptr) + i, NUM_LANES));
            if (!w_found && r_credit[w_scan]) begin
                w_found = 1'b1;
                w_grant = w_scan;
            end
        end
    end

    assign w_pop = w_found && (w_count != '0) && !bus.flush_i;

    // Dispatch wins over a same-cycle pre_ready, so the granted lane ends without credit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_credit <= '1;
            r_rr_ptr <= '0;
            r_valid  <= '0;
            for (int k = 0; k < NUM_LANES; k++)
                r_data[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_LANES; k++) begin
                r_valid[k] <= w_pop && (w_grant == LW'(k));
                if (w_pop && (w_grant == LW'(k))) begin
                    r_credit[k] <= 1'b0;
                    r_data[k]   <= w_fifo_data;
                end else if (bus.lane_pre_ready_i[k]) begin
                    r_credit[k] <= 1'b1;
                end
            end
            if (w_pop)
                r_rr_ptr <= LW'(lane_wrap(int'(w_grant) + 1, NUM_LANES));
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane_out
            assign bus.lane_data_o[gi*DATA_W +: DATA_W] = r_data[gi];
        end
    endgenerate

    assign bus.lane_valid_o  = r_valid;
    assign bus.count_o       = w_count;
    assign bus.full_o        = w_full;
    assign bus.almost_full_o = w_almost_full;
    assign bus.overflow_o    = w_overflow;

endmodule

// File: tb/tb_stage_dispatch.sv
// Directed bench for stage_dispatch with DATA_W=64, DEPTH=16, NUM_LANES=2, AFULL_TH=14.
module tb_stage_dispatch;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    stage_dispatch_if #(.DATA_W(64), .DEPTH(16), .NUM_LANES(2)) bus ();

    stage_dispatch #(
        .DATA_W    (64),
        .DEPTH     (16),
        .NUM_LANES (2),
        .AFULL_TH  (14)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_valid_i       = 1'b0;
        bus.wr_data_i        = '0;
        bus.flush_i          = 1'b0;
        bus.lane_pre_ready_i = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic push(input logic [63:0] d);
        bus.wr_valid_i = 1'b1;
        bus.wr_data_i  = d;
        step();
        bus.wr_valid_i = 1'b0;
        $display("push data=%h count=%0d valid=%b", d, bus.count_o, bus.lane_valid_o);
    endtask

    // Leaves both lanes without credit, rr pointer at lane 0 and the FIFO empty.
    task automatic consume_credits();
        do_reset();
        push(64'h0000_0000_0000_0A00);
        push(64'h0000_0000_0000_0A01);
        step();
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        step();
        step();
        checks++;
        if (bus.lane_valid_o !== 2'b00 || bus.lane_data_o !== 128'h0 || bus.count_o !== 5'd0 ||
            bus.full_o !== 1'b0 || bus.almost_full_o !== 1'b0 || bus.overflow_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got valid=%b data=%h count=%0d full=%b af=%b ovf=%b required all zero",
                     bus.lane_valid_o, bus.lane_data_o, bus.count_o, bus.full_o, bus.almost_full_o, bus.overflow_o);
        end
        rst_n = 1'b1;
        push(64'h1111_2222_3333_4444);
        rst_n = 1'b0;
        step();
        checks++;
        if (bus.lane_valid_o !== 2'b00 || bus.count_o !== 5'd0) begin
            failures++;
            $display("FAIL reset_midop got valid=%b count=%0d required valid=00 count=0",
                     bus.lane_valid_o, bus.count_o);
        end
        rst_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_single();
        do_reset();
        push(64'h0123_4567_89AB_CDEF);
        checks++;
        if (bus.count_o !== 5'd1 || bus.lane_valid_o !== 2'b00) begin
            failures++;
            $display("FAIL single_c1 got count=%0d valid=%b required count=1 valid=00", bus.count_o, bus.lane_valid_o);
        end
        step();
        checks++;
        if (bus.lane_valid_o !== 2'b01 || bus.lane_data_o[63:0] !== 64'h0123_4567_89AB_CDEF || bus.count_o !== 5'd0) begin
            failures++;
            $display("FAIL single_c2 got valid=%b data0=%h count=%0d required valid=01 data0=0123456789abcdef count=0",
                     bus.lane_valid_o, bus.lane_data_o[63:0], bus.count_o);
        end
        step();
        checks++;
        if (bus.lane_valid_o !== 2'b00 || bus.lane_data_o[63:0] !== 64'h0123_4567_89AB_CDEF) begin
            failures++;
            $display("FAIL single_hold got valid=%b data0=%h required valid=00 data0 held",
                     bus.lane_valid_o, bus.lane_data_o[63:0]);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        push(64'hAAAA_0000_0000_000A);
        push(64'hBBBB_0000_0000_000B);
        checks++;
        if (bus.lane_valid_o !== 2'b01 || bus.lane_data_o[63:0] !== 64'hAAAA_0000_0000_000A) begin
            failures++;
            $display("FAIL b2b_A got valid=%b data0=%h required valid=01 data0=aaaa00000000000a",
                     bus.lane_valid_o, bus.lane_data_o[63:0]);
        end
        push(64'hCCCC_0000_0000_000C);
        checks++;
        if (bus.lane_valid_o !== 2'b10 || bus.lane_data_o[127:64] !== 64'hBBBB_0000_0000_000B) begin
            failures++;
            $display("FAIL b2b_B got valid=%b data1=%h required valid=10 data1=bbbb00000000000b",
                     bus.lane_valid_o, bus.lane_data_o[127:64]);
        end
        push(64'hDDDD_0000_0000_000D);
        step();
        checks++;
        if (bus.count_o !== 5'd2 || bus.lane_valid_o !== 2'b00) begin
            failures++;
            $display("FAIL b2b_stall got count=%0d valid=%b required count=2 valid=00", bus.count_o, bus.lane_valid_o);
        end
        bus.lane_pre_ready_i = 2'b10;
        step();
        bus.lane_pre_ready_i = 2'b00;
        step();
        checks++;
        if (bus.lane_valid_o !== 2'b10 || bus.lane_data_o[127:64] !== 64'hCCCC_0000_0000_000C ||
            bus.lane_data_o[63:0] !== 64'hAAAA_0000_0000_000A || bus.count_o !== 5'd1) begin
            failures++;
            $display("FAIL b2b_C got valid=%b data1=%h data0=%h count=%0d required valid=10 data1=C data0=A count=1",
                     bus.lane_valid_o, bus.lane_data_o[127:64], bus.lane_data_o[63:0], bus.count_o);
        end
        bus.lane_pre_ready_i = 2'b01;
        step();
        bus.lane_pre_ready_i = 2'b00;
        step();
        checks++;
        if (bus.lane_valid_o !== 2'b01 || bus.lane_data_o[63:0] !== 64'hDDDD_0000_0000_000D ||
            bus.lane_data_o[127:64] !== 64'hCCCC_0000_0000_000C || bus.count_o !== 5'd0) begin
            failures++;
            $display("FAIL b2b_D got valid=%b data0=%h data1=%h count=%0d required valid=01 data0=D data1=C count=0",
                     bus.lane_valid_o, bus.lane_data_o[63:0], bus.lane_data_o[127:64], bus.count_o);
        end
    endtask

    task automatic test_overflow();
        logic [4:0] exp_cnt;
        consume_credits();
        for (int i = 0; i < 17; i++) begin
            push(64'hE000_0000_0000_0000 | 64'(i));
            exp_cnt = (i < 16) ? 5'(i + 1) : 5'd16;
            checks++;
            if (bus.count_o !== exp_cnt || bus.almost_full_o !== (exp_cnt >= 5'd14) ||
                bus.full_o !== (exp_cnt == 5'd16) || bus.overflow_o !== (i == 16)) begin
                failures++;
                $display("FAIL fill_%0d got count=%0d af=%b full=%b ovf=%b required count=%0d af=%b full=%b ovf=%b",
                         i, bus.count_o, bus.almost_full_o, bus.full_o, bus.overflow_o,
                         exp_cnt, (exp_cnt >= 5'd14), (exp_cnt == 5'd16), (i == 16));
            end
        end
        step();
        bus.lane_pre_ready_i = 2'b01;
        step();
        bus.lane_pre_ready_i = 2'b00;
        checks++;
        if (bus.count_o !== 5'd16 || bus.full_o !== 1'b1) begin
            failures++;
            $display("FAIL ovf_hold got count=%0d full=%b required count=16 full=1", bus.count_o, bus.full_o);
        end
        step();
        checks++;
        if (bus.lane_valid_o !== 2'b01 || bus.lane_data_o[63:0] !== 64'hE000_0000_0000_0000 ||
            bus.count_o !== 5'd15 || bus.full_o !== 1'b0 || bus.overflow_o !== 1'b1) begin
            failures++;
            $display("FAIL ovf_pop got valid=%b data0=%h count=%0d full=%b ovf=%b required 01 e000000000000000 15 0 1",
                     bus.lane_valid_o, bus.lane_data_o[63:0], bus.count_o, bus.full_o, bus.overflow_o);
        end
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        checks++;
        if (bus.overflow_o !== 1'b0 || bus.count_o !== 5'd0 || bus.almost_full_o !== 1'b0) begin
            failures++;
            $display("FAIL ovf_flush got ovf=%b count=%0d af=%b required ovf=0 count=0 af=0",
                     bus.overflow_o, bus.count_o, bus.almost_full_o);
        end
    endtask

    task automatic test_full_push_pop();
        consume_credits();
        for (int i = 0; i < 16; i++)
            push(64'hF000_0000_0000_0000 | 64'(i));
        bus.lane_pre_ready_i = 2'b01;
        step();
        bus.lane_pre_ready_i = 2'b00;
        push(64'hF000_0000_0000_0010);
        checks++;
        if (bus.count_o !== 5'd16 || bus.overflow_o !== 1'b0 || bus.full_o !== 1'b1 ||
            bus.lane_valid_o !== 2'b01 || bus.lane_data_o[63:0] !== 64'hF000_0000_0000_0000) begin
            failures++;
            $display("FAIL full_pushpop got count=%0d ovf=%b full=%b valid=%b data0=%h required 16 0 1 01 f000000000000000",
                     bus.count_o, bus.overflow_o, bus.full_o, bus.lane_valid_o, bus.lane_data_o[63:0]);
        end
    endtask

    task automatic test_flush();
        consume_credits();
        for (int i = 0; i < 5; i++)
            push(64'h5000_0000_0000_0000 | 64'(i));
        checks++;
        if (bus.count_o !== 5'd5) begin
            failures++;
            $display("FAIL flush_pre got count=%0d required 5", bus.count_o);
        end
        bus.lane_pre_ready_i = 2'b01;
        step();
        bus.lane_pre_ready_i = 2'b10;
        bus.flush_i          = 1'b1;
        step();
        bus.lane_pre_ready_i = 2'b00;
        bus.flush_i          = 1'b0;
        checks++;
        if (bus.lane_valid_o !== 2'b00 || bus.count_o !== 5'd0 || bus.overflow_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_clear got valid=%b count=%0d ovf=%b required valid=00 count=0 ovf=0",
                     bus.lane_valid_o, bus.count_o, bus.overflow_o);
        end
        step();
        checks++;
        if (bus.lane_valid_o !== 2'b00) begin
            failures++;
            $display("FAIL flush_novalid got valid=%b required 00", bus.lane_valid_o);
        end
        push(64'h5555_6666_7777_8888);
        step();
        checks++;
        if (bus.lane_valid_o !== 2'b01 || bus.lane_data_o[63:0] !== 64'h5555_6666_7777_8888) begin
            failures++;
            $display("FAIL flush_after got valid=%b data0=%h required valid=01 data0=5555666677778888",
                     bus.lane_valid_o, bus.lane_data_o[63:0]);
        end
    endtask

    task automatic test_pre_ready_credit();
        do_reset();
        bus.lane_pre_ready_i = 2'b01;
        push(64'h6000_0000_0000_000A);
        step();
        bus.lane_pre_ready_i = 2'b00;
        checks++;
        if (bus.lane_valid_o !== 2'b01 || bus.lane_data_o[63:0] !== 64'h6000_0000_0000_000A) begin
            failures++;
            $display("FAIL cred_A got valid=%b data0=%h required valid=01 data0=600000000000000a",
                     bus.lane_valid_o, bus.lane_data_o[63:0]);
        end
        push(64'h6000_0000_0000_000B);
        checks++;
        if (bus.lane_valid_o !== 2'b00) begin
            failures++;
            $display("FAIL cred_extra got valid=%b required 00", bus.lane_valid_o);
        end
        step();
        checks++;
        if (bus.lane_valid_o !== 2'b10 || bus.lane_data_o[127:64] !== 64'h6000_0000_0000_000B) begin
            failures++;
            $display("FAIL cred_B got valid=%b data1=%h required valid=10 data1=600000000000000b",
                     bus.lane_valid_o, bus.lane_data_o[127:64]);
        end
        step();
        bus.lane_pre_ready_i = 2'b10;
        step();
        bus.lane_pre_ready_i = 2'b00;
        push(64'h6000_0000_0000_000C);
        step();
        checks++;
        if (bus.lane_valid_o !== 2'b10 || bus.lane_data_o[127:64] !== 64'h6000_0000_0000_000C ||
            bus.lane_data_o[63:0] !== 64'h6000_0000_0000_000A) begin
            failures++;
            $display("FAIL cred_C got valid=%b data1=%h data0=%h required valid=10 data1=C data0=A",
                     bus.lane_valid_o, bus.lane_data_o[127:64], bus.lane_data_o[63:0]);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        idle_inputs();
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_push_pop();
        test_flush();
        test_pre_ready_credit();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
